// File: rtl/conv_relu_pool2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_relu_pool2_pkg
// Brief    : Shared constants, FSM encoding and signed max helper.
// Revision : 1.0
// ============================================================================
package conv_relu_pool2_pkg;

  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int CNT_W = 5;
  localparam int POS_W = 4;

  localparam logic [0:0] S_TOP = 1'b0;
  localparam logic [0:0] S_BOT = 1'b1;

  function automatic logic signed [DW-1:0] smax(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_relu_pool2_relu_hmax_lane.sv
`default_nettype none
// ============================================================================
// Module   : relu_hmax_lane
// Brief    : Per-lane ReLU on an even/odd pair followed by horizontal max.
// Revision : 1.0
// ============================================================================
module relu_hmax_lane
  import conv_relu_pool2_pkg::*;
(
  input  logic signed [DW-1:0] d0,
  input  logic signed [DW-1:0] d1,
  output logic signed [DW-1:0] h
);

  logic signed [DW-1:0] w_r0;
  logic signed [DW-1:0] w_r1;

  // Negative values clamp to zero, so the sign bit alone selects the ReLU.
  assign w_r0 = d0[DW-1] ? '0 : d0;
  assign w_r1 = d1[DW-1] ? '0 : d1;
  assign h    = smax(w_r0, w_r1);

endmodule
`default_nettype wire

// File: rtl/conv_relu_pool2.sv
`default_nettype none
// ============================================================================
// Module   : conv_relu_pool2
// Brief    : ReLU + 2x2 max-pool over paired conv beats, valid/ready in/out.
// Revision : 1.0
// ============================================================================
module conv_relu_pool2
  import conv_relu_pool2_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*DW-1:0]  in_data0,
  input  logic [LANES*DW-1:0]  in_data1,
  input  logic [CNT_W-1:0]     cnt_in,
  input  logic [POS_W-1:0]     pos_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*DW-1:0]  out_data,
  output logic [CNT_W-2:0]     cnt_out,
  output logic [POS_W-1:0]     pos_out,
  output logic                 row_err
);

  logic [0:0]           r_state;
  logic [0:0]           w_next_state;
  logic signed [DW-1:0] w_h   [LANES];
  logic signed [DW-1:0] r_top [LANES];
  logic [POS_W-1:0]     r_top_pos;
  logic [LANES*DW-1:0]  w_pool;
  logic                 w_accept;
  logic                 w_top_acc;
  logic                 w_bot_acc;
  logic                 w_row_err;

  // Lane 0 sits at the most-significant end of each bus.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    relu_hmax_lane u_lane (
      .d0 (in_data0[(LANES-1-i)*DW +: DW]),
      .d1 (in_data1[(LANES-1-i)*DW +: DW]),
      .h  (w_h[i])
    );
  end

  assign w_accept  = in_valid & in_ready;
  assign w_top_acc = w_accept & (r_state == S_TOP);
  assign w_bot_acc = w_accept & (r_state == S_BOT);
  assign w_row_err = (w_top_acc & cnt_in[0]) |
                     (w_bot_acc & (~cnt_in[0] | (pos_in != r_top_pos)));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= S_TOP;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_accept) w_next_state = (r_state == S_TOP) ? S_BOT : S_TOP;
  end

  // A bottom beat may enter while the output drains in the same cycle.
  always_comb begin
    in_ready = 1'b1;
    if (r_state == S_BOT) in_ready = ~out_valid | out_ready;
  end

  always_comb begin
    w_pool = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pool[(LANES-1-i)*DW +: DW] = smax(r_top[i], w_h[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < LANES; i++) r_top[i] <= '0;
      r_top_pos <= '0;
    end else if (w_top_acc) begin
      for (int i = 0; i < LANES; i++) r_top[i] <= w_h[i];
      r_top_pos <= pos_in;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      cnt_out   <= '0;
      pos_out   <= '0;
    end else if (w_bot_acc) begin
      out_valid <= 1'b1;
      out_data  <= w_pool;
      cnt_out   <= cnt_in[CNT_W-1:1];
      pos_out   <= pos_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)         row_err <= 1'b0;
    else if (w_row_err) row_err <= 1'b1;
  end

endmodule
`default_nettype wire
